// File: rtl/common_fifo_2pop_pkg.sv
// Shared definitions for the dual-pop FIFO.
// Holds the pop-count encoding shared with the dual-issue decode stage
// (POP_NONE / POP_ONE / POP_TWO). It also holds a helper that turns a raw
// 2-bit pop request into the number of entries actually requested.
package common_fifo_2pop_pkg;

    localparam logic [1:0] POP_NONE = 2'd0;
    localparam logic [1:0] POP_ONE  = 2'd1;
    localparam logic [1:0] POP_TWO  = 2'd2;

    // Encoding 3 is not a legal request; it saturates to two pops.
    function automatic logic [1:0] clip_pop_req(input logic [1:0] pop_num);
        logic [1:0] req;
        case (pop_num)
            POP_NONE: req = POP_NONE;
            POP_ONE:  req = POP_ONE;
            POP_TWO:  req = POP_TWO;
            default:  req = POP_TWO;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/common_fifo_2pop_if.sv
// Handshake bundle for common_fifo_2pop.
// The slave side is the FIFO. The master side is the producer/consumer that
// pushes entries, observes the two head entries and requests pops.
//   flush, i_push_valid, i_push_data, i_pop_num : master -> FIFO
//   o_push_ready, o_head0_*, o_head1_*, o_count   : FIFO -> master
interface common_fifo_2pop_if
    import common_fifo_2pop_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH = 3
);
    logic                       flush;
    logic                       i_push_valid;
    logic                       o_push_ready;
    logic [FIFO_DATA_WIDTH-1:0] i_push_data;
    logic                       o_head0_valid;
    logic [FIFO_DATA_WIDTH-1:0] o_head0_data;
    logic                       o_head1_valid;
    logic [FIFO_DATA_WIDTH-1:0] o_head1_data;
    logic [1:0]                 i_pop_num;
    logic [FIFO_ADDR_WIDTH:0]   o_count;

    modport master (
        output flush, i_push_valid, i_push_data, i_pop_num,
        input  o_push_ready, o_head0_valid, o_head0_data,
               o_head1_valid, o_head1_data, o_count
    );

    modport slave (
        input  flush, i_push_valid, i_push_data, i_pop_num,
        output o_push_ready, o_head0_valid, o_head0_data,
               o_head1_valid, o_head1_data, o_count
    );
endinterface

// File: rtl/common_dffram_3a1wb2r.sv
// Flip-flop RAM with three addresses: write port A with per-bit enables, and
// two combinational read ports B and C.
// Ports:
//   clk, reset       clock and synchronous active-high reset (contents := RAM_RESET_VALUE)
//   a_addr/a_we/a_bit_en/a_wdata   write port
//   b_addr/b_rdata, c_addr/c_rdata combinational read ports
module common_dffram_3a1wb2r
    import common_fifo_2pop_pkg::*;
#(
    parameter int                        RAM_DATA_WIDTH  = 32,
    parameter int                        RAM_ADDR_WIDTH  = 3,
    parameter logic [RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = {RAM_DATA_WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
    input  logic                      a_we,
    input  logic [RAM_DATA_WIDTH-1:0] a_bit_en,
    input  logic [RAM_DATA_WIDTH-1:0] a_wdata,
    input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
    output logic [RAM_DATA_WIDTH-1:0] b_rdata,
    input  logic [RAM_ADDR_WIDTH-1:0] c_addr,
    output logic [RAM_DATA_WIDTH-1:0] c_rdata
);
    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    logic [RAM_DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

    // Storage array: reset to a known value, then bit-masked writes on port A.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem_r[i] <= RAM_RESET_VALUE;
            end
        end else if (a_we) begin
            mem_r[a_addr] <= (mem_r[a_addr] & ~a_bit_en) | (a_wdata & a_bit_en);
        end
    end

    assign b_rdata = mem_r[b_addr];
    assign c_rdata = mem_r[c_addr];

endmodule

// File: rtl/common_fifo_2pop.sv
// Synchronous FIFO that pops up to two entries per cycle. The two oldest
// entries are presented combinationally from the RAM read ports. This module
// is the pointer/occupancy controller around common_dffram_3a1wb2r.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   fifo_if     slave side of common_fifo_2pop_if (push, heads, pop, flush, count)
module common_fifo_2pop
    import common_fifo_2pop_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    common_fifo_2pop_if.slave fifo_if
);
    localparam int                     DEPTH     = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = DEPTH[FIFO_ADDR_WIDTH:0];

    logic [FIFO_ADDR_WIDTH-1:0] wptr_r;
    logic [FIFO_ADDR_WIDTH-1:0] rptr_r;
    logic [FIFO_ADDR_WIDTH:0]   count_r;

    logic                       push_ready_s;
    logic                       push_fire_s;
    logic [FIFO_ADDR_WIDTH:0]   pop_req_s;
    logic [FIFO_ADDR_WIDTH:0]   pop_eff_s;
    logic [FIFO_ADDR_WIDTH-1:0] rptr_plus1_s;
    logic [FIFO_ADDR_WIDTH-1:0] wptr_nxt_s;
    logic [FIFO_ADDR_WIDTH-1:0] rptr_nxt_s;
    logic [FIFO_ADDR_WIDTH:0]   count_nxt_s;

    // Ready comes from registered occupancy only, so a same-cycle pop never
    // frees a slot for a same-cycle push.
    assign push_ready_s = (count_r != DEPTH_CNT);
    assign push_fire_s  = fifo_if.i_push_valid & push_ready_s & ~fifo_if.flush;
    assign rptr_plus1_s = rptr_r + {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Pop clipping and next-state computation; flush discards everything.
    always_comb begin
        pop_req_s = (FIFO_ADDR_WIDTH+1)'(clip_pop_req(fifo_if.i_pop_num));
        // Over-pop is clipped to the current occupancy, so the count never underflows.
        if (count_r < pop_req_s) begin
            pop_eff_s = count_r;
        end else begin
            pop_eff_s = pop_req_s;
        end
        if (fifo_if.flush) begin
            wptr_nxt_s  = {FIFO_ADDR_WIDTH{1'b0}};
            rptr_nxt_s  = {FIFO_ADDR_WIDTH{1'b0}};
            count_nxt_s = {(FIFO_ADDR_WIDTH+1){1'b0}};
        end else begin
            wptr_nxt_s  = wptr_r + {{(FIFO_ADDR_WIDTH-1){1'b0}}, push_fire_s};
            rptr_nxt_s  = rptr_r + pop_eff_s[FIFO_ADDR_WIDTH-1:0];
            count_nxt_s = count_r + {{FIFO_ADDR_WIDTH{1'b0}}, push_fire_s} - pop_eff_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= {FIFO_ADDR_WIDTH{1'b0}};
            rptr_r  <= {FIFO_ADDR_WIDTH{1'b0}};
            count_r <= {(FIFO_ADDR_WIDTH+1){1'b0}};
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    common_dffram_3a1wb2r #(
        .RAM_DATA_WIDTH (FIFO_DATA_WIDTH),
        .RAM_ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .RAM_RESET_VALUE({FIFO_DATA_WIDTH{1'b0}})
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .a_addr  (wptr_r),
        .a_we    (push_fire_s),
        .a_bit_en({FIFO_DATA_WIDTH{1'b1}}),
        .a_wdata (fifo_if.i_push_data),
        .b_addr  (rptr_r),
        .b_rdata (fifo_if.o_head0_data),
        .c_addr  (rptr_plus1_s),
        .c_rdata (fifo_if.o_head1_data)
    );

    assign fifo_if.o_push_ready  = push_ready_s;
    assign fifo_if.o_head0_valid = (count_r != {(FIFO_ADDR_WIDTH+1){1'b0}});
    assign fifo_if.o_head1_valid = (count_r >= (FIFO_ADDR_WIDTH+1)'(2));
    assign fifo_if.o_count       = count_r;

endmodule

// File: tb/tb_common_fifo_2pop.sv
module tb_common_fifo_2pop;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    common_fifo_2pop_if #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) fifo_if ();

    common_fifo_2pop #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .fifo_if(fifo_if)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Compare observable state against the scoreboard queue.
    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check_value({tag, ".count"}, 64'(fifo_if.o_count), 64'(n));
        check_value({tag, ".ready"}, 64'(fifo_if.o_push_ready), 64'(n != DEPTH));
        check_value({tag, ".h0v"}, 64'(fifo_if.o_head0_valid), 64'(n >= 1));
        check_value({tag, ".h1v"}, 64'(fifo_if.o_head1_valid), 64'(n >= 2));
        if (n >= 1) check_value({tag, ".h0d"}, 64'(fifo_if.o_head0_data), 64'(model_q[0]));
        if (n >= 2) check_value({tag, ".h1d"}, 64'(fifo_if.o_head1_data), 64'(model_q[1]));
    endtask

    // One clock of stimulus: check the state on entry, then apply the cycle to the model.
    task automatic step(input string tag, input logic pv, input logic [DW-1:0] pd,
                        input logic [1:0] pn, input logic fl);
        int  n;
        int  pe;
        logic fire;
        @(negedge clk);
        fifo_if.i_push_valid = pv;
        fifo_if.i_push_data  = pd;
        fifo_if.i_pop_num    = pn;
        fifo_if.flush        = fl;
        #1;
        check_state(tag);
        n    = model_q.size();
        fire = pv && (n != DEPTH) && !fl;
        pe   = (pn == 2'd3) ? 2 : int'(pn);
        if (pe > n) pe = n;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            for (int k = 0; k < pe; k++) void'(model_q.pop_front());
            if (fire) model_q.push_back(pd);
        end
    endtask

    // Reset with a push in flight; everything returns to reset values.
    task automatic do_reset(input string tag, input logic pv, input logic [DW-1:0] pd);
        @(negedge clk);
        reset                = 1'b1;
        fifo_if.i_push_valid = pv;
        fifo_if.i_push_data  = pd;
        fifo_if.i_pop_num    = 2'd0;
        fifo_if.flush        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset                = 1'b0;
        fifo_if.i_push_valid = 1'b0;
        model_q.delete();
        #1;
        check_state(tag);
        check_value({tag, ".h0d_zero"}, 64'(fifo_if.o_head0_data), 64'h0);
        check_value({tag, ".h1d_zero"}, 64'(fifo_if.o_head1_data), 64'h0);
    endtask

    initial begin
        reset                = 1'b1;
        fifo_if.flush        = 1'b0;
        fifo_if.i_push_valid = 1'b0;
        fifo_if.i_push_data  = 32'h0;
        fifo_if.i_pop_num    = 2'd0;
        repeat (2) @(posedge clk);

        // 1. reset then idle
        do_reset("t1_reset", 1'b0, 32'h0);
        step("t1_idle", 1'b0, 32'h0, 2'd0, 1'b0);

        // 2. fill, then refused push
        step("t2_p1", 1'b1, 32'hA1, 2'd0, 1'b0);
        step("t2_p2", 1'b1, 32'hA2, 2'd0, 1'b0);
        step("t2_p3", 1'b1, 32'hA3, 2'd0, 1'b0);
        step("t2_p4", 1'b1, 32'hA4, 2'd0, 1'b0);
        step("t2_p5", 1'b1, 32'hA5, 2'd0, 1'b0);

        // 3. pop two from full with a refused push
        step("t3_pop2", 1'b1, 32'hB1, 2'd2, 1'b0);

        // 4. wrap of read port C, then pop_num=3 clipped to count
        step("t4_a", 1'b1, 32'hC0, 2'd1, 1'b0);
        step("t4_wrap", 1'b1, 32'hC1, 2'd1, 1'b0);
        step("t4_pop1", 1'b0, 32'h0, 2'd1, 1'b0);
        step("t4_pop3", 1'b0, 32'h0, 2'd3, 1'b0);

        // 5. over-pop on empty together with a push
        step("t5_overpop", 1'b1, 32'hD1, 2'd2, 1'b0);

        // 6. flush at count 3 with a push, then push after flush
        step("t6_p1", 1'b1, 32'hD2, 2'd0, 1'b0);
        step("t6_p2", 1'b1, 32'hD3, 2'd0, 1'b0);
        step("t6_flush", 1'b1, 32'hE1, 2'd0, 1'b1);
        step("t6_pushF", 1'b1, 32'hF1, 2'd0, 1'b0);
        step("t6_seeF", 1'b0, 32'h0, 2'd0, 1'b0);
        do_reset("t6_reset", 1'b1, 32'hF2);
        step("t6_idle", 1'b0, 32'h0, 2'd0, 1'b0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom(),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end
        step("final", 1'b0, 32'h0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
